// File: rtl/acc_time_ctrl_v2_core.sv
// Delay-and-stretch stage for the ACC result flag: replays the gated result level
// max(D,2) clocks later and stretches each pulse by H clocks, edges queued in a FIFO.

// Generic show-ahead FIFO: rd_dat presents the head whenever rd_vld is high.
// Latency: an entry written on one edge is visible on rd_dat after that edge.
// Backpressure: writes while full are ignored; the writer gates on level.
module acc_edge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_vld,
  input  logic [W-1:0]           wr_dat,
  input  logic                   rd_rdy,
  output logic                   rd_vld,
  output logic [W-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign level  = wr_ptr - rd_ptr;
  assign rd_vld = (level != '0);
  assign wr_en  = wr_vld && (level != FULL_LVL);
  assign rd_en  = rd_rdy && rd_vld;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

// Delays the gated ACC result by max(D,2) clocks and holds each pulse H clocks longer.
// Latency: input rise sampled at edge k shows on filter_acc_flag_o at edge k+Deff+1.
// Backpressure: none upstream; a pulse that cannot fit in the edge FIFO is dropped whole.
module acc_time_ctrl_v2_core #(
  parameter int EDGE_FIFO_DEPTH = 32,
  parameter int CNT_W           = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             filter_unit_flag_i,
  input  logic             filter_acc_result_i,
  input  logic [CNT_W-1:0] acc_delay_i,
  input  logic [CNT_W-1:0] acc_hold_i,
  output logic             filter_acc_flag_o
);
  localparam int AW = $clog2(EDGE_FIFO_DEPTH);
  // A rise is only accepted while two slots remain, so its fall always fits.
  localparam logic [AW:0]      RISE_ROOM = {1'b0, {AW{1'b1}}};
  localparam logic [CNT_W-1:0] MIN_DLY   = {{(CNT_W-2){1'b0}}, 2'b10};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             e_q;
  logic             e_q_d;
  logic             drop_pend;
  logic             dly;
  logic             dly_nx;
  logic [CNT_W-1:0] tnow;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nx;
  logic [CNT_W-1:0] d_eff;
  logic [CNT_W-1:0] slack;
  logic             edge_det;
  logic             rise_ok;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   push_dat;
  logic [CNT_W:0]   head_dat;
  logic             head_vld;
  logic             head_pol;
  logic [CNT_W-1:0] head_tgt;
  logic [AW:0]      level;

  assign edge_det = e_q ^ e_q_d;
  assign rise_ok  = (level < RISE_ROOM);
  assign push     = edge_det && (e_q ? rise_ok : !drop_pend);
  assign d_eff    = (acc_delay_i < MIN_DLY) ? MIN_DLY : acc_delay_i;
  assign push_dat = {e_q, tnow + d_eff};

  assign head_pol = head_dat[CNT_W];
  assign head_tgt = head_dat[CNT_W-1:0];
  // Wrap-safe "tnow has reached target": sign bit of the modular difference.
  assign slack    = tnow - head_tgt;
  assign pop      = head_vld && !slack[CNT_W-1];

  acc_edge_fifo #(
    .W     (CNT_W + 1),
    .DEPTH (EDGE_FIFO_DEPTH)
  ) u_edge_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_vld (push),
    .wr_dat (push_dat),
    .rd_rdy (pop),
    .rd_vld (head_vld),
    .rd_dat (head_dat),
    .level  (level)
  );

  always_comb begin
    dly_nx  = dly;
    hold_nx = hold_cnt;
    if (pop) begin
      dly_nx  = head_pol;
      hold_nx = head_pol ? '0 : acc_hold_i;
    end else if ((hold_cnt != '0) && !dly) begin
      hold_nx = hold_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_q               <= 1'b0;
      e_q_d             <= 1'b0;
      drop_pend         <= 1'b0;
      tnow              <= '0;
      dly               <= 1'b0;
      hold_cnt          <= '0;
      filter_acc_flag_o <= 1'b0;
    end else begin
      e_q               <= filter_acc_result_i & filter_unit_flag_i;
      e_q_d             <= e_q;
      tnow              <= tnow + CNT_ONE;
      dly               <= dly_nx;
      hold_cnt          <= hold_nx;
      // Registered from next-state values so the output adds no extra clock.
      filter_acc_flag_o <= dly_nx | (hold_nx != '0);
      if (edge_det) begin
        if (e_q && !rise_ok) drop_pend <= 1'b1;
        else if (!e_q)       drop_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_acc_time_ctrl_v2_core.sv
// Bench for acc_time_ctrl_v2_core: table-driven pulse timing, directed corner
// sequences, and randomized traffic checked every cycle against an event-queue model.
module tb_acc_time_ctrl_v2_core;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en = 1'b1;
  logic        res = 1'b0;
  logic [31:0] d_cfg = 32'd2;
  logic [31:0] h_cfg = 32'd0;
  logic        flag;

  always #5 clk = ~clk;

  acc_time_ctrl_v2_core #(
    .EDGE_FIFO_DEPTH (DEPTH),
    .CNT_W           (32)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .filter_unit_flag_i  (en),
    .filter_acc_result_i (res),
    .acc_delay_i         (d_cfg),
    .acc_hold_i          (h_cfg),
    .filter_acc_flag_o   (flag)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: edges become timed events in a queue; the output is high
  // from a rise event until its fall event plus the hold time.
  typedef struct {
    logic pol;
    int   due;
  } ev_t;
  ev_t  mq[$];
  logic m_ok = 1'b0, m_exp = 1'b0, m_e_last = 1'b0, m_e = 1'b0;
  logic m_pend_vld = 1'b0, m_pend_pol = 1'b0, m_drop = 1'b0, m_high = 1'b0;
  int   m_hold_end = 0, m_cnt = 0, m_deff = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_i) begin
      mq.delete();
      m_e_last = 1'b0; m_pend_vld = 1'b0; m_drop = 1'b0;
      m_high = 1'b0; m_hold_end = 0; m_exp = 1'b0; m_ok = 1'b1;
    end else begin
      m_cnt = mq.size();
      if (m_pend_vld) begin
        m_deff = (d_cfg < 32'd2) ? 2 : int'(d_cfg);
        if (m_pend_pol) begin
          if (m_cnt <= DEPTH - 2) mq.push_back('{pol: 1'b1, due: cyc + m_deff});
          else m_drop = 1'b1;
        end else begin
          if (m_drop) m_drop = 1'b0;
          else mq.push_back('{pol: 1'b0, due: cyc + m_deff});
        end
      end
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        if (mq[0].pol) begin
          m_high = 1'b1;
        end else begin
          m_high = 1'b0;
          m_hold_end = cyc + int'(h_cfg);
        end
        void'(mq.pop_front());
      end
      m_exp = m_high || (cyc < m_hold_end);
      m_e = res & en;
      m_pend_vld = (m_e != m_e_last);
      m_pend_pol = m_e;
      m_e_last = m_e;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (m_ok) begin
      n_cmp++;
      if (flag !== m_exp) begin
        n_bad++;
        $display("FAIL model cyc=%0d flag=%0b expected=%0b", cyc, flag, m_exp);
      end
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  logic res_q[$];
  logic en_q[$];
  int   rise_q[$];
  int   fall_q[$];
  int   k0 = 0;

  function automatic int rise_at(input int i);
    return (rise_q.size() > i) ? rise_q[i] : -1;
  endfunction

  function automatic int fall_at(input int i);
    return (fall_q.size() > i) ? fall_q[i] : -1;
  endfunction

  task automatic add_seg(input logic lvl, input int n);
    repeat (n) begin
      res_q.push_back(lvl);
      en_q.push_back(1'b1);
    end
  endtask

  // Applies queued per-cycle inputs and records output edges relative to the
  // edge that sampled the first input (k0).
  task automatic play(input int ncyc);
    logic prev;
    rise_q.delete();
    fall_q.delete();
    prev = flag;
    for (int i = 0; i < ncyc; i++) begin
      res = (i < res_q.size()) ? res_q[i] : 1'b0;
      en  = (i < en_q.size()) ? en_q[i] : 1'b1;
      tick();
      if (i == 0) k0 = cyc;
      if (flag && !prev) rise_q.push_back(cyc - k0);
      if (!flag && prev) fall_q.push_back(cyc - k0);
      prev = flag;
    end
    res_q.delete();
    en_q.delete();
    res = 1'b0;
    en  = 1'b1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    res   = 1'b0;
    en    = 1'b1;
    tick();
    rst_i = 1'b0;
    check("reset_flag", int'(flag), 0);
  endtask

  typedef struct {
    int d;
    int h;
    int w;
    int lat;
    int width;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int run;
    vecs[0] = '{d: 0,  h: 0,  w: 1, lat: 3,  width: 1};
    vecs[1] = '{d: 1,  h: 0,  w: 1, lat: 3,  width: 1};
    vecs[2] = '{d: 2,  h: 0,  w: 3, lat: 3,  width: 3};
    vecs[3] = '{d: 5,  h: 3,  w: 4, lat: 6,  width: 7};
    vecs[4] = '{d: 10, h: 0,  w: 1, lat: 11, width: 1};
    vecs[5] = '{d: 7,  h: 2,  w: 1, lat: 8,  width: 3};
    vecs[6] = '{d: 3,  h: 10, w: 6, lat: 4,  width: 16};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      d_cfg = vecs[i].d;
      h_cfg = vecs[i].h;
      do_reset();
      add_seg(1'b1, vecs[i].w);
      play(vecs[i].w + vecs[i].lat + vecs[i].h + 10);
      check("vec_pulses", rise_q.size(), 1);
      check("vec_latency", rise_at(0), vecs[i].lat);
      check("vec_width", fall_at(0) - rise_at(0), vecs[i].width);
    end

    // Long delay with hold: two separate output pulses.
    d_cfg = 200; h_cfg = 100;
    do_reset();
    add_seg(1'b1, 120); add_seg(1'b0, 220); add_seg(1'b1, 20);
    play(720);
    check("long_pulses", rise_q.size(), 2);
    check("long_rise0", rise_at(0), 201);
    check("long_fall0", fall_at(0), 421);
    check("long_rise1", rise_at(1), 541);
    check("long_fall1", fall_at(1), 661);

    // Gaps shorter than the hold merge into one pulse.
    d_cfg = 10; h_cfg = 50;
    do_reset();
    repeat (4) begin
      add_seg(1'b1, 5);
      add_seg(1'b0, 20);
    end
    play(250);
    check("merge_pulses", rise_q.size(), 1);
    check("merge_rise", rise_at(0), 11);
    check("merge_fall", fall_at(0), 141);

    // Enable low gates everything.
    d_cfg = 3; h_cfg = 2;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      res_q.push_back(1'($urandom_range(0, 1)));
      en_q.push_back(1'b0);
    end
    play(120);
    check("en_off_pulses", rise_q.size(), 0);

    // Enable dropped mid-pulse acts as the fall.
    d_cfg = 10; h_cfg = 5;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      res_q.push_back(1'b1);
      en_q.push_back(i < 8);
    end
    play(60);
    check("en_drop_pulses", rise_q.size(), 1);
    check("en_drop_rise", rise_at(0), 11);
    check("en_drop_fall", fall_at(0), 24);

    // Edge FIFO overflow: first 16 pulses survive, the rest vanish whole.
    d_cfg = 5000; h_cfg = 0;
    do_reset();
    repeat (40) begin
      add_seg(1'b1, 2);
      add_seg(1'b0, 2);
    end
    play(5200);
    check("ovf_pulses", rise_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check("ovf_rise", rise_at(i), 5001 + 4 * i);
      check("ovf_fall", fall_at(i), 5003 + 4 * i);
    end
    check("ovf_final_low", int'(flag), 0);

    // Reset while the output is high and edges are still queued.
    d_cfg = 20; h_cfg = 10;
    do_reset();
    add_seg(1'b1, 30); add_seg(1'b0, 5); add_seg(1'b1, 10);
    play(45);
    check("pre_reset_high", int'(flag), 1);
    do_reset();
    play(150);
    check("post_reset_pulses", rise_q.size(), 0);

    // Randomized traffic with occasional config changes and resets.
    d_cfg = 20; h_cfg = 3;
    do_reset();
    run = 0;
    for (int n = 0; n < 4000; n++) begin
      if (run == 0) begin
        res = 1'($urandom_range(0, 1));
        en  = ($urandom_range(0, 7) != 0);
        run = int'($urandom_range(1, 6));
      end
      run--;
      if (n % 500 == 499) begin
        d_cfg = $urandom_range(0, 150);
        h_cfg = $urandom_range(0, 12);
      end
      rst_i = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst_i = 1'b0;
    res   = 1'b0;
    repeat (200) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
